pp_uart_tx_unpacker: RTL and testbench



---
 rtl/pp_uart_tx_unpacker_pkg.sv | 12 +
 rtl/pp_frame_fifo.sv | 44 ++++
 rtl/pp_uart_tx_unpacker.sv | 214 +++++++++++++++++++++
 tb/tb_pp_uart_tx_unpacker.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pp_uart_tx_unpacker_pkg.sv
// Shared constants for the periplex UART group path: UART count, frame byte capacities, entry type codes.
`ifndef TOTAL_UART
`define TOTAL_UART 8
`endif

package pp_uart_tx_unpacker_pkg;
  localparam int TOTAL_UART = `TOTAL_UART;
  localparam int HEAD_BYTES = 4;
  localparam int CONT_BYTES = 6;
  localparam logic ENTRY_DATA = 1'b0;
  localparam logic ENTRY_CFG  = 1'b1;
endpackage

// File: rtl/pp_frame_fifo.sv
// Synchronous frame FIFO with full/empty flags; a push while full is taken when a pop frees a slot the same cycle.
module pp_frame_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/pp_uart_tx_unpacker.sv
// Unpacks decoded UART-group frames into a byte stream and config write strobes.
// Optional PP_UART_TX_STATS_EN adds stat_bytes / stat_drops counters.
module pp_uart_tx_unpacker
  import pp_uart_tx_unpacker_pkg::*;
#(
  parameter int SEL_WIDTH   = 7,
  parameter int LEN_WIDTH   = 7,
  parameter int VALUE_WIDTH = 48,
  parameter int NUM_UART    = TOTAL_UART,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   uart_grp_en,
  input  logic [SEL_WIDTH-1:0]   slv_sel,
  input  logic                   cfg,
  input  logic [LEN_WIDTH-1:0]   str_len,
  input  logic [VALUE_WIDTH-1:0] value,
  input  logic                   flag_frame_1,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [7:0]             tx_data,
  output logic [SEL_WIDTH-1:0]   tx_sel,
  output logic                   tx_last,
  output logic                   cfg_wr,
  output logic [SEL_WIDTH-1:0]   cfg_sel,
  output logic [31:0]            cfg_data,
  output logic                   ovf,
  input  logic                   ovf_clr,
  output logic                   busy
`ifdef PP_UART_TX_STATS_EN
  ,
  output logic [15:0]            stat_bytes,
  output logic [7:0]             stat_drops
`endif
);
  localparam int ENTRY_W = VALUE_WIDTH + SEL_WIDTH + 5;
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  function automatic logic [2:0] take_bytes(input logic [LEN_WIDTH-1:0] avail,
                                            input logic [2:0] cap);
    if (avail < LEN_WIDTH'(cap)) return avail[2:0];
    return cap;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [LEN_WIDTH-1:0]   remaining, rem_nxt;
  logic [SEL_WIDTH-1:0]   pkt_sel;
  logic                   pkt_bad;
  logic                   head, sel_ok, open_pkt;
  logic                   push_req, bad_frame, drop;
  logic                   e_type, e_last;
  logic [SEL_WIDTH-1:0]   e_sel;
  logic [2:0]             e_nb;
  logic [VALUE_WIDTH-1:0] e_data;
  logic [ENTRY_W-1:0]     fifo_din, fifo_dout;
  logic                   fifo_full, fifo_empty, pop;
  logic                   d_type, d_last;
  logic [SEL_WIDTH-1:0]   d_sel;
  logic [2:0]             d_nb;
  logic [VALUE_WIDTH-1:0] d_data;
  logic [0:0]             state;
  logic [2:0]             cnt;
  logic                   cur_last, tx_hs, final_byte;
  logic [VALUE_WIDTH-1:0] shifter;
  logic [SEL_WIDTH-1:0]   cur_sel, cfg_sel_q;
  logic [31:0]            cfg_data_q;
  logic                   unused_ok;

  assign unused_ok = flag_frame_1;

  // Write side: frame classification and entry build
  assign head   = (remaining == '0);
  assign sel_ok = ({1'b0, slv_sel} < (SEL_WIDTH+1)'(NUM_UART));

  always_comb begin
    push_req  = 1'b0;
    bad_frame = 1'b0;
    open_pkt  = 1'b0;
    rem_nxt   = remaining;
    e_type    = ENTRY_DATA;
    e_sel     = pkt_sel;
    e_nb      = '0;
    e_data    = value;
    if (uart_grp_en) begin
      if (head) begin
        e_sel  = slv_sel;
        e_data = {{(VALUE_WIDTH-32){1'b0}}, value[31:0]};
        if (cfg) begin
          e_type    = ENTRY_CFG;
          push_req  = sel_ok;
          bad_frame = !sel_ok;
        end else if (str_len != '0) begin
          open_pkt  = 1'b1;
          e_nb      = take_bytes(str_len, 3'(HEAD_BYTES));
          rem_nxt   = str_len - LEN_WIDTH'(e_nb);
          push_req  = sel_ok;
          bad_frame = !sel_ok;
        end
      end else begin
        e_nb      = take_bytes(remaining, 3'(CONT_BYTES));
        rem_nxt   = remaining - LEN_WIDTH'(e_nb);
        push_req  = !pkt_bad;
        bad_frame = pkt_bad;
      end
    end
    e_last = (rem_nxt == '0);
  end

  assign drop     = push_req && fifo_full && !pop;
  assign fifo_din = {e_type, e_sel, e_nb, e_last, e_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= '0;
      pkt_bad   <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      remaining <= rem_nxt;
      if (open_pkt) pkt_bad <= !sel_ok;
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (open_pkt) pkt_sel <= slv_sel;
  end

  pp_frame_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Read side: pop, shift out bytes, issue config strobes
  assign {d_type, d_sel, d_nb, d_last, d_data} = fifo_dout;

  assign tx_valid   = (state == S_SHIFT);
  assign tx_hs      = tx_valid && tx_ready;
  assign final_byte = tx_hs && (cnt == 3'd1);
  assign pop        = !fifo_empty && ((state == S_IDLE) || final_byte);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      cur_last <= 1'b0;
      cfg_wr   <= 1'b0;
    end else begin
      cfg_wr <= 1'b0;
      if (pop) begin
        if (d_type == ENTRY_CFG) begin
          cfg_wr   <= 1'b1;
          state    <= S_IDLE;
          cnt      <= '0;
          cur_last <= 1'b0;
        end else begin
          state    <= S_SHIFT;
          cnt      <= d_nb;
          cur_last <= d_last;
        end
      end else if (final_byte) begin
        state    <= S_IDLE;
        cnt      <= '0;
        cur_last <= 1'b0;
      end else if (tx_hs) begin
        cnt <= cnt - 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      shifter <= d_data;
      cur_sel <= d_sel;
      if (d_type == ENTRY_CFG) begin
        cfg_sel_q  <= d_sel;
        cfg_data_q <= d_data[31:0];
      end
    end else if (tx_hs) begin
      shifter <= shifter >> 8;
    end
  end

  assign tx_data  = tx_valid ? shifter[7:0] : 8'd0;
  assign tx_sel   = tx_valid ? cur_sel : '0;
  assign tx_last  = tx_valid && cur_last && (cnt == 3'd1);
  assign cfg_sel  = cfg_wr ? cfg_sel_q : '0;
  assign cfg_data = cfg_wr ? cfg_data_q : 32'd0;
  assign busy     = !fifo_empty || (state == S_SHIFT) || (remaining != '0);

`ifdef PP_UART_TX_STATS_EN
  // Statistics: wrapping byte count, saturating drop count
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_bytes <= '0;
      stat_drops <= '0;
    end else begin
      if (tx_hs) stat_bytes <= stat_bytes + 16'd1;
      if (drop || bad_frame) stat_drops <= sat_inc8(stat_drops);
    end
  end
`endif
endmodule

// File: tb/tb_pp_uart_tx_unpacker.sv
// Directed and randomized bench for pp_uart_tx_unpacker against a packet-level byte/config model.
module tb_pp_uart_tx_unpacker;
  localparam int SEL_W    = 7;
  localparam int LEN_W    = 7;
  localparam int VAL_W    = 48;
  localparam int NUM_UART = 8;
  localparam int DEPTH    = 4;

  logic             clk = 1'b0;
  logic             rst, uart_grp_en, cfg, flag_frame_1, tx_ready, ovf_clr;
  logic [SEL_W-1:0] slv_sel;
  logic [LEN_W-1:0] str_len;
  logic [VAL_W-1:0] value;
  logic             tx_valid, tx_last, cfg_wr, ovf, busy;
  logic [7:0]       tx_data;
  logic [SEL_W-1:0] tx_sel, cfg_sel;
  logic [31:0]      cfg_data;

  typedef struct { logic [7:0] data; logic [6:0] sel; logic last; } byte_t;
  typedef struct { logic [6:0] sel; logic [31:0] data; } cfg_t;

  byte_t      exp_q[$];
  cfg_t       cfg_q[$];
  logic [7:0] pkt [128];
  int         checks = 0;
  int         errors = 0;
  int         seen_bytes = 0;
  bit         rand_ready = 1'b0;

  always #5 clk = ~clk;

  pp_uart_tx_unpacker #(
    .SEL_WIDTH(SEL_W), .LEN_WIDTH(LEN_W), .VALUE_WIDTH(VAL_W),
    .NUM_UART(NUM_UART), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .uart_grp_en(uart_grp_en), .slv_sel(slv_sel), .cfg(cfg),
    .str_len(str_len), .value(value), .flag_frame_1(flag_frame_1),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_sel(tx_sel),
    .tx_last(tx_last), .cfg_wr(cfg_wr), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .ovf(ovf), .ovf_clr(ovf_clr), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    byte_t e;
    cfg_t  c;
    if (tx_valid && tx_ready) begin
      seen_bytes++;
      chk("tx_byte_expected", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("tx_data", tx_data, e.data);
        chk("tx_sel", tx_sel, e.sel);
        chk("tx_last", tx_last, e.last);
      end
    end
    if (cfg_wr) begin
      chk("cfg_wr_expected", 64'(cfg_q.size() != 0), 1);
      if (cfg_q.size() != 0) begin
        c = cfg_q.pop_front();
        chk("cfg_sel", cfg_sel, c.sel);
        chk("cfg_data", cfg_data, c.data);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (rand_ready) tx_ready = ($urandom % 4) != 0;
  endtask

  task automatic frame(input logic c, input logic [6:0] s, input logic [6:0] len,
                       input logic [47:0] v);
    cfg = c; slv_sel = s; str_len = len; value = v;
    flag_frame_1 = 1'($urandom); uart_grp_en = 1'b1;
    tick();
    uart_grp_en = 1'b0;
    cfg = 1'($urandom); slv_sel = 7'($urandom); str_len = 7'($urandom);
    value = 48'({$urandom(), $urandom()});
  endtask

  task automatic wait_idle();
    int n = 0;
    while (tx_valid && n < 300) begin tick(); n++; end
    if (n >= 300) chk("wait_idle_timeout", 64'(n), 0);
  endtask

  // Splits pkt[0..len-1] into a head frame plus continuations; garbage fills unused lanes.
  task automatic send_packet(input logic [6:0] sel, input int len, input bit pace,
                             input bit exp_out);
    int idx, rem;
    logic [47:0] v;
    for (int i = len; i < 128; i++) pkt[i] = 8'($urandom);
    if (exp_out && sel < NUM_UART)
      for (int i = 0; i < len; i++) exp_q.push_back('{pkt[i], sel, (i == len - 1)});
    v = {16'($urandom), pkt[3], pkt[2], pkt[1], pkt[0]};
    if (pace) wait_idle();
    frame(1'b0, sel, 7'(len), v);
    idx = (len < 4) ? len : 4;
    rem = len - idx;
    while (rem > 0) begin
      v = {pkt[idx+5], pkt[idx+4], pkt[idx+3], pkt[idx+2], pkt[idx+1], pkt[idx]};
      if (pace) wait_idle();
      frame(1'($urandom), 7'($urandom), 7'($urandom), v);
      idx += 6;
      rem -= (rem < 6) ? rem : 6;
    end
  endtask

  task automatic settle();
    int n = 0;
    rand_ready = 1'b0;
    tx_ready = 1'b1;
    while ((exp_q.size() != 0 || cfg_q.size() != 0 || busy) && n < 400) begin tick(); n++; end
    repeat (3) tick();
    chk("bytes_drained", 64'(exp_q.size()), 0);
    chk("cfgs_drained", 64'(cfg_q.size()), 0);
    chk("busy_after_drain", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, n;
    rst = 1'b1; uart_grp_en = 1'b0; cfg = 1'b0; slv_sel = '0; str_len = '0; value = '0;
    flag_frame_1 = 1'b0; tx_ready = 1'b1; ovf_clr = 1'b0;
    repeat (3) tick();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_last", tx_last, 0);
    chk("rst_cfg_wr", cfg_wr, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // Short head-only packet, latency of two cycles
    pkt[0] = 8'hAA; pkt[1] = 8'hBB; pkt[2] = 8'hCC;
    send_packet(7'd2, 3, 1'b0, 1'b1);
    chk("lat_n1_valid", tx_valid, 0);
    tick();
    chk("lat_n2_valid", tx_valid, 1);
    chk("lat_n2_data", tx_data, 8'hAA);
    settle();

    // Head plus two continuations, 14 bytes
    for (int i = 0; i < 14; i++) pkt[i] = 8'(i + 1);
    send_packet(7'd5, 14, 1'b0, 1'b1);
    settle();

    // Config frame
    cfg_q.push_back('{7'd1, 32'h0001C200});
    frame(1'b1, 7'd1, 7'($urandom), 48'h00000001C200);
    chk("cfg_lat_n1", cfg_wr, 0);
    tick();
    chk("cfg_lat_n2", cfg_wr, 1);
    settle();

    // Out-of-range sel consumes its continuation silently; next packet framed normally
    for (int i = 0; i < 10; i++) pkt[i] = 8'($urandom);
    send_packet(7'(NUM_UART), 10, 1'b0, 1'b0);
    pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h33;
    send_packet(7'd0, 3, 1'b0, 1'b1);
    settle();

    // Overflow under backpressure: one entry in shifter plus four buffered
    tx_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      pkt[0] = 8'(8'h40 + 2*k); pkt[1] = 8'(8'h41 + 2*k);
      send_packet(7'(k), 2, 1'b0, 1'b1);
    end
    chk("ovf_before_full_push", ovf, 0);
    send_packet(7'd6, 2, 1'b0, 1'b0);
    chk("ovf_after_drop", ovf, 1);
    ovf_clr = 1'b1;
    send_packet(7'd7, 2, 1'b0, 1'b0);
    ovf_clr = 1'b0;
    chk("ovf_clr_vs_new_drop", ovf, 1);
    chk("busy_while_full", busy, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", ovf, 0);
    settle();

    // Reset in the middle of a 6-byte packet
    for (int i = 0; i < 6; i++) pkt[i] = 8'(8'h60 + i);
    send_packet(7'd3, 6, 1'b0, 1'b1);
    base = seen_bytes;
    n = 0;
    while (seen_bytes - base < 2 && n < 50) begin tick(); n++; end
    chk("two_bytes_before_reset", 64'(seen_bytes - base), 2);
    rst = 1'b1; tx_ready = 1'b0;
    tick();
    rst = 1'b0;
    chk("post_rst_tx_valid", tx_valid, 0);
    chk("post_rst_busy", busy, 0);
    exp_q.delete();
    tx_ready = 1'b1;
    tick();
    chk("post_rst_idle", tx_valid, 0);
    pkt[0] = 8'h5A; pkt[1] = 8'hA5;
    send_packet(7'd4, 2, 1'b0, 1'b1);
    settle();

    // Randomized mix of packets and config frames with random backpressure
    rand_ready = 1'b1;
    for (int it = 0; it < 60; it++) begin
      if ($urandom % 5 == 0) begin
        logic [6:0]  s;
        logic [47:0] v;
        s = 7'($urandom_range(0, NUM_UART + 1));
        v = 48'({$urandom(), $urandom()});
        if (s < NUM_UART) cfg_q.push_back('{s, v[31:0]});
        wait_idle();
        frame(1'b1, s, 7'($urandom), v);
      end else begin
        int len;
        len = $urandom_range(0, 20);
        for (int i = 0; i < len; i++) pkt[i] = 8'($urandom);
        send_packet(7'($urandom_range(0, NUM_UART)), len, 1'b1, 1'b1);
      end
    end
    settle();
    chk("random_no_ovf", ovf, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
